cla_sub_seq: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor: D = A - B - bin. Counterpart to the team's combinational CLA adder.

---
 rtl/cla_pkg.sv | 14 +
 rtl/sub_nibble_cla.sv | 34 +++
 rtl/cla_sub_seq.sv | 121 ++++++++++++
 tb/tb_cla_sub_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead subtractor.
//   sub_state_t : FSM states of cla_sub_seq
//   SLICE_W     : width of one lookahead slice (one slice per RUN cycle)
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/sub_nibble_cla.sv
// 4-bit carry-lookahead adder slice: s = x + y + cin, cout = carry out.
// Ports:
//   x, y  in  4  addend nibbles
//   cin   in  1  carry in
//   s     out 4  sum nibble
//   cout  out 1  carry out
module sub_nibble_cla (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Carries flattened from the propagate/generate terms so no carry ripples.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit
// lookahead slice per cycle, LSB nibble first, borrow chained in a register.
// Optional feature macro: SUB_OVF_FLAG_EN (signed overflow flag on ovf).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow in
//   out_valid / out_ready result handshake (valid only in DONE)
//   diff, bout           difference and borrow out (1 iff a < b + bin)
//   ovf                  signed overflow, tied 0 without SUB_OVF_FLAG_EN
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("cla_sub_seq: WIDTH must be a positive multiple of 4");
    end

    sub_state_t       state, state_nx;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r, b_r, diff_r;
    logic             carry, bout_r;
    logic [3:0]       xn, yn, sn;
    logic             cn;
    logic             accept;

    assign accept = in_valid && (state == IDLE);

    // Subtraction as a + ~b + ~bin: carry register holds the inverted borrow.
    assign xn = a_r[int'(idx)*SLICE_W +: SLICE_W];
    assign yn = ~b_r[int'(idx)*SLICE_W +: SLICE_W];

    sub_nibble_cla u_slice (
        .x    (xn),
        .y    (yn),
        .cin  (carry),
        .s    (sn),
        .cout (cn)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)    state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            carry  <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                carry <= ~bin;
                idx   <= '0;
            end
            if (state == RUN) begin
                diff_r[int'(idx)*SLICE_W +: SLICE_W] <= sn;
                carry <= cn;
                idx   <= idx + 1'b1;
                if (idx == LAST) bout_r <= ~cn;
            end
        end
    end

`ifdef SUB_OVF_FLAG_EN
    logic ovf_r;

    // Final slice's sum MSB is the result MSB, so the flag registers with bout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf_r <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (sn[3] ^ a_r[WIDTH-1]);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule

// File: tb/tb_cla_sub_seq.sv
module tb_cla_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cla_sub_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: wait for in_ready, accept, check latency and result,
    // stall in DONE for 'stall' cycles while offering a decoy operand, release.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tbin, input int stall);
        logic [16:0] full;
        logic [15:0] ed;
        logic        eb, eo;
        int          n;
        full = {1'b0, ta} - {1'b0, tb} - {16'd0, tbin};
        ed   = full[15:0];
        eb   = full[16];
`ifdef SUB_OVF_FLAG_EN
        eo   = (ta[15] != tb[15]) && (ed[15] != ta[15]);
`else
        eo   = 1'b0;
`endif
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        bin = tbin;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta;
        b = ta ^ 16'h5a5a;
        bin = ~tbin;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 32'd4);
        chk("diff", {16'd0, diff}, {16'd0, ed});
        chk("bout", {31'd0, bout}, {31'd0, eb});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_diff", {16'd0, diff}, {16'd0, ed});
            chk("stall_bout", {31'd0, bout}, {31'd0, eb});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 16'h0;
        b = 16'h0;
        bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_diff", {16'd0, diff}, 32'd0);
        chk("reset_bout", {31'd0, bout}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0034, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'h0005, 16'h0005, 1'b1, 0);
        run_op(16'h1000, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Backpressure with a decoy in_valid held through the handoff edge.
        run_op(16'hABCD, 16'h1234, 1'b0, 3);
        @(negedge clk);
        chk("no_accept_on_handoff", {31'd0, out_valid}, 32'd0);
        chk("idle_after_handoff", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of RUN (slice 2 being computed).
        in_valid = 1'b1;
        a = 16'h4321;
        b = 16'h1111;
        bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_diff", {16'd0, diff}, 32'd0);
        chk("midrun_rst_bout", {31'd0, bout}, 32'd0);
        run_op(16'h4321, 16'h1111, 1'b0, 0);

        // Reset while stalled in DONE.
        in_valid = 1'b1;
        a = 16'h0000;
        b = 16'h0002;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("done_stalled_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_rst_diff", {16'd0, diff}, 32'd0);
        chk("done_rst_bout", {31'd0, bout}, 32'd0);

        // Signed overflow vectors (flag expected 0 in the default build).
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        run_op(16'h0003, 16'h0001, 1'b0, 1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
